// File: rtl/shreg_sequencer.sv
// shreg_sequencer: command sequencer driving the 4-bit shift/load/invert
// register controls (shift,load,pdata) over a valid/ready command port.
// Ports: clk, reset (async, active-high), cmd_valid/cmd_ready/cmd_op/
//   cmd_data/cmd_count (command in), reg_q (register feedback),
//   shift/load/pdata (register controls), busy, done, shifts_done.
// Optional build macro: SEQ_EARLY_ZERO_EN -- stop SHIFT early once
//   reg_q reads all zeros.
module shreg_sequencer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [3:0]       reg_q,
   output logic             shift,
   output logic             load,
   output logic [3:0]       pdata,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] shifts_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SHIFT = 2'b01;
   localparam logic [1:0] OP_INV   = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_op;
   logic [3:0]       r_data;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_sd;
   logic             w_accept;
   logic             w_inc;
   logic             w_shift;
   logic             w_load;

`ifdef SEQ_EARLY_ZERO_EN
   logic w_zero;
   assign w_zero = (reg_q == 4'b0000);
`else
   logic w_unused_q;
   assign w_unused_q = ^reg_q;
`endif

   assign w_accept = (r_state == S_IDLE) && cmd_valid;

   always_comb begin
      w_next  = r_state;
      w_shift = 1'b1;
      w_load  = 1'b1;
      w_inc   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               unique case (cmd_op)
                  OP_LOAD:  w_next = S_RUN;
                  OP_INV:   w_next = S_RUN;
                  OP_SHIFT: w_next = (cmd_count != '0) ? S_RUN : S_DONE;
                  OP_NOP:   w_next = S_DONE;
                  default:  w_next = S_DONE;
               endcase
            end
         end
         S_RUN: begin
            unique case (r_op)
               OP_LOAD: begin
                  w_shift = 1'b0;
                  w_next  = S_DONE;
               end
               OP_INV: begin
                  w_load = 1'b0;
                  w_next = S_DONE;
               end
               OP_SHIFT: begin
`ifdef SEQ_EARLY_ZERO_EN
                  // all-zero register: further shifts are no-ops, stop now
                  if (w_zero) begin
                     w_next = S_DONE;
                  end else begin
                     w_shift = 1'b0;
                     w_load  = 1'b0;
                     w_inc   = 1'b1;
                     if (r_cnt == ONE) w_next = S_DONE;
                  end
`else
                  w_shift = 1'b0;
                  w_load  = 1'b0;
                  w_inc   = 1'b1;
                  if (r_cnt == ONE) w_next = S_DONE;
`endif
               end
               default: w_next = S_DONE;
            endcase
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_op    <= OP_NOP;
         r_data  <= 4'b0000;
         r_cnt   <= '0;
         r_sd    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op  <= cmd_op;
            r_cnt <= cmd_count;
            r_sd  <= '0;
            // pdata only tracks LOAD payloads so it stays 0 until one arrives
            if (cmd_op == OP_LOAD) r_data <= cmd_data;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - ONE;
            if (w_inc) r_sd <= r_sd + ONE;
         end
      end
   end

   assign shift       = w_shift;
   assign load        = w_load;
   assign pdata       = r_data;
   assign cmd_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign shifts_done = r_sd;

endmodule

// File: tb/tb_shreg_sequencer.sv
// tb_shreg_sequencer: directed self-checking bench for shreg_sequencer
// with a behavioural model of the 4-bit shift/load/invert register.
module tb_shreg_sequencer;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [3:0] cmd_count;
   logic [3:0] reg_q;
   logic       shift;
   logic       load;
   logic [3:0] pdata;
   logic       busy;
   logic       done;
   logic [3:0] shifts_done;

   int n_chk;
   int n_err;

   localparam logic [1:0] LD = 2'b00;
   localparam logic [1:0] SH = 2'b01;
   localparam logic [1:0] IV = 2'b10;
   localparam logic [1:0] NP = 2'b11;

   shreg_sequencer #(.CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_data    (cmd_data),
      .cmd_count   (cmd_count),
      .reg_q       (reg_q),
      .shift       (shift),
      .load        (load),
      .pdata       (pdata),
      .busy        (busy),
      .done        (done),
      .shifts_done (shifts_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // the lab register being controlled; not reset by the sequencer
   logic [3:0] r_reg;
   initial r_reg = 4'b0000;
   always @(posedge clk) begin
      case ({shift, load})
         2'b00:   r_reg <= {r_reg[2:0], 1'b0};
         2'b01:   r_reg <= pdata;
         2'b10:   r_reg <= ~r_reg;
         default: r_reg <= r_reg;
      endcase
   end
   assign reg_q = r_reg;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the IDLE
   // cycle after done, so back-to-back calls exercise full throughput.
   task automatic do_cmd(input logic [1:0] op, input logic [3:0] d,
                         input logic [3:0] c, input int n_run,
                         input logic [3:0] exp_reg,
                         input logic [3:0] exp_sd);
      logic [3:0] er;
      logic [1:0] ectl;
      chk("ready_pre", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_count = c;
      @(negedge clk);
      cmd_valid = 1'b0;
      er = r_reg;
      for (int i = 0; i < n_run; i++) begin
         case (op)
            LD:      ectl = 2'b01;
            IV:      ectl = 2'b10;
            default: ectl = 2'b00;
         endcase
`ifdef SEQ_EARLY_ZERO_EN
         if (op == SH && er == 4'b0000) ectl = 2'b11;
`endif
         chk("run_ctl", 32'({shift, load}), 32'(ectl));
         chk("run_busy", 32'(busy), 32'd1);
         chk("run_done", 32'(done), 32'd0);
         chk("run_ready", 32'(cmd_ready), 32'd0);
         if (op == LD) chk("run_pdata", 32'(pdata), 32'(d));
         if (op == SH) begin
            chk("run_reg", 32'(r_reg), 32'(er));
            er = er << 1;
         end
         @(negedge clk);
      end
      chk("done", 32'(done), 32'd1);
      chk("done_ctl", 32'({shift, load}), 32'd3);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_ready", 32'(cmd_ready), 32'd0);
      chk("done_sd", 32'(shifts_done), 32'(exp_sd));
      chk("done_reg", 32'(r_reg), 32'(exp_reg));
      @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_sd", 32'(shifts_done), 32'(exp_sd));
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = NP;
      cmd_data  = 4'b0000;
      cmd_count = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ready", 32'(cmd_ready), 32'd1);
         chk("idle_ctl", 32'({shift, load}), 32'd3);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_pdata", 32'(pdata), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      do_cmd(LD, 4'b1011, 4'd0, 1, 4'b1011, 4'd0);
      do_cmd(SH, 4'b0000, 4'd3, 3, 4'b1000, 4'd3);
      chk("pdata_hold", 32'(pdata), 32'hB);
      do_cmd(LD, 4'b0101, 4'd0, 1, 4'b0101, 4'd0);
      do_cmd(IV, 4'b0000, 4'd0, 1, 4'b1010, 4'd0);
      do_cmd(SH, 4'b0000, 4'd0, 0, 4'b1010, 4'd0);
      do_cmd(NP, 4'b0000, 4'd0, 0, 4'b1010, 4'd0);

      do_cmd(LD, 4'b0100, 4'd0, 1, 4'b0100, 4'd0);
`ifdef SEQ_EARLY_ZERO_EN
      do_cmd(SH, 4'b0000, 4'd10, 3, 4'b0000, 4'd2);
      do_cmd(LD, 4'b0000, 4'd0, 1, 4'b0000, 4'd0);
      do_cmd(SH, 4'b0000, 4'd3, 1, 4'b0000, 4'd0);
`else
      do_cmd(SH, 4'b0000, 4'd10, 10, 4'b0000, 4'd10);
`endif

      // reset during the 2nd RUN cycle of SHIFT 5
      do_cmd(LD, 4'b0001, 4'd0, 1, 4'b0001, 4'd0);
      cmd_valid = 1'b1;
      cmd_op    = SH;
      cmd_count = 4'd5;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rst_run1_ctl", 32'({shift, load}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_ctl", 32'({shift, load}), 32'd3);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sd", 32'(shifts_done), 32'd0);
      chk("rst_pdata", 32'(pdata), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_nodone", 32'(done), 32'd0);
         chk("rst_idle", 32'(cmd_ready), 32'd1);
      end
      chk("rst_reg", 32'(r_reg), 32'b0010);

      do_cmd(LD, 4'b0111, 4'd0, 1, 4'b0111, 4'd0);
      do_cmd(SH, 4'b0000, 4'd2, 2, 4'b1100, 4'd2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
